// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and types for the MIPS pipeline control
//               slice. This covers the register-zero index, the HI/LO unit
//               latency defaults, the NOP encoding, the MD FSM states and the
//               pipeline control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [4:0]  REG_ZERO       = 5'd0;
    localparam int          DEF_MUL_CYCLES = 4;
    localparam int          DEF_DIV_CYCLES = 32;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Per-cycle load/flush decisions for the pipeline registers.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_flush;
    } pipe_ctrl_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Hazard inputs and pipeline-register controls exchanged
//               between the datapath (master) and the hazard controller
//               (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;

    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_uses_hilo;
    logic        ex_is_load;
    logic [4:0]  ex_wreg;
    logic        ex_md_start;
    logic        ex_md_is_div;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ready;

    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_en;
    logic        idex_flush;
    logic        exmem_en;
    logic        memwb_flush;
    logic        md_busy;
    logic        hilo_we;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo,
               ex_is_load, ex_wreg, ex_md_start, ex_md_is_div,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_flush, md_busy, hilo_we, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo,
               ex_is_load, ex_wreg, ex_md_start, ex_md_is_div,
               ex_branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_flush, md_busy, hilo_we, stall_cycles
    );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/md_busy_tracker.sv
`default_nettype none
// ============================================================================
// Module      : md_busy_tracker
// Description : Tracks occupancy of the multi-cycle MULT/DIV unit that owns
//               HI/LO. A countdown runs while BUSY, and a one-cycle hilo_we
//               strobe is raised on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module md_busy_tracker
    import mips_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES,
    parameter int CNT_W      = 6
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_start,
    input  wire logic i_is_div,
    output logic      o_md_busy,
    output logic      o_hilo_we
);

    localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_hilo_we;
    logic             w_hilo_we_nxt;

    // State, countdown and completion strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_hilo_we <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hilo_we <= w_hilo_we_nxt;
        end
    end

    // Next-state logic: a start request is honoured only from IDLE; the
    // countdown keeps running through memory stalls.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hilo_we_nxt = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (i_start) begin
                    w_state_nxt = MD_BUSY;
                    w_cnt_nxt   = i_is_div ? C_DIV_LOAD : C_MUL_LOAD;
                end
            end
            MD_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt   = MD_IDLE;
                    w_hilo_we_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
            end
        endcase
    end

    assign o_md_busy = (r_state == MD_BUSY);
    assign o_hilo_we = r_hilo_we;

endmodule : md_busy_tracker
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Per-cycle load/hold/bubble sequencing of the five-stage MIPS
//               pipeline registers. It handles memory wait states, taken
//               branches, load-use hazards and HI/LO occupancy, and keeps a
//               saturating count of fetch-stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES,
    parameter int CNT_W      = 6
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam pipe_ctrl_t C_CTRL_RESET = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                            idex_en: 1'b0, idex_flush: 1'b1,
                                            exmem_en: 1'b0, memwb_flush: 1'b1};
    localparam pipe_ctrl_t C_CTRL_RUN   = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                            idex_en: 1'b1, idex_flush: 1'b0,
                                            exmem_en: 1'b1, memwb_flush: 1'b0};

    logic        w_memw;
    logic        w_lu;
    logic        w_exmem_go;
    logic        w_mdh;
    logic        w_md_start;
    logic        w_md_busy;
    logic        w_hilo_we;
    pipe_ctrl_t  w_ctrl;
    logic [31:0] r_stall_cycles;

    // EX/MEM advances unless memory is waiting. The HI/LO hazard depends on
    // this, so it is computed apart from the full priority mux to keep the
    // logic free of loops.
    assign w_memw     = bus.mem_req & ~bus.mem_ready;
    assign w_exmem_go = ~rst & ~w_memw;
    assign w_lu       = bus.ex_is_load & (bus.ex_wreg != REG_ZERO) &
                        ((bus.id_uses_rs & (bus.id_rs == bus.ex_wreg)) |
                         (bus.id_uses_rt & (bus.id_rt == bus.ex_wreg)));
    assign w_mdh      = bus.id_uses_hilo & (w_md_busy | (bus.ex_md_start & w_exmem_go));
    assign w_md_start = bus.ex_md_start & w_ctrl.exmem_en;

    // Hazard priority. A memory wait freezes everything, including a pending
    // branch. A taken branch squashes the ID instruction, so any hazard it
    // carries no longer matters.
    always_comb begin
        w_ctrl = C_CTRL_RUN;
        if (rst) begin
            w_ctrl = C_CTRL_RESET;
        end else if (w_memw) begin
            w_ctrl             = '0;
            w_ctrl.memwb_flush = 1'b1;
        end else if (bus.ex_branch_taken) begin
            w_ctrl.ifid_flush = 1'b1;
            w_ctrl.idex_flush = 1'b1;
        end else if (w_lu | w_mdh) begin
            w_ctrl.pc_en      = 1'b0;
            w_ctrl.ifid_en    = 1'b0;
            w_ctrl.idex_flush = 1'b1;
        end
    end

    // Saturating count of cycles in which fetch was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (!w_ctrl.pc_en && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    md_busy_tracker #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_busy_tracker (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_md_start),
        .i_is_div  (bus.ex_md_is_div),
        .o_md_busy (w_md_busy),
        .o_hilo_we (w_hilo_we)
    );

    assign bus.pc_en        = w_ctrl.pc_en;
    assign bus.ifid_en      = w_ctrl.ifid_en;
    assign bus.ifid_flush   = w_ctrl.ifid_flush;
    assign bus.idex_en      = w_ctrl.idex_en;
    assign bus.idex_flush   = w_ctrl.idex_flush;
    assign bus.exmem_en     = w_ctrl.exmem_en;
    assign bus.memwb_flush  = w_ctrl.memwb_flush;
    assign bus.md_busy      = w_md_busy;
    assign bus.hilo_we      = w_hilo_we;
    assign bus.stall_cycles = r_stall_cycles;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    // Control vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_flush
    localparam logic [6:0] C_RESET = 7'b0010101;
    localparam logic [6:0] C_RUN   = 7'b1101010;
    localparam logic [6:0] C_STALL = 7'b0001110;
    localparam logic [6:0] C_BRNCH = 7'b1111110;
    localparam logic [6:0] C_MEMW  = 7'b0000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   exp_stall = 0;
    int   busy_n;
    logic saw_we;

    pipe_hazard_ctrl_if intf ();

    pipe_hazard_ctrl #(
        .MUL_CYCLES (4),
        .DIV_CYCLES (32),
        .CNT_W      (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctrl_vec();
        return {intf.pc_en, intf.ifid_en, intf.ifid_flush, intf.idex_en,
                intf.idex_flush, intf.exmem_en, intf.memwb_flush};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        intf.id_rs = 5'd0;           intf.id_rt = 5'd0;
        intf.id_uses_rs = 1'b0;      intf.id_uses_rt = 1'b0;
        intf.id_uses_hilo = 1'b0;    intf.ex_is_load = 1'b0;
        intf.ex_wreg = 5'd0;         intf.ex_md_start = 1'b0;
        intf.ex_md_is_div = 1'b0;    intf.ex_branch_taken = 1'b0;
        intf.mem_req = 1'b0;         intf.mem_ready = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_ctrl", 32'(ctrl_vec()), 32'(C_RESET));
        chk("reset_busy", 32'(intf.md_busy), 32'd0);
        chk("reset_hilo_we", 32'(intf.hilo_we), 32'd0);
        chk("reset_stall", intf.stall_cycles, 32'd0);

        rst = 1'b0;
        #1;
        chk("idle_ctrl", 32'(ctrl_vec()), 32'(C_RUN));
        tick();
        chk("idle_stall", intf.stall_cycles, 32'd0);

        // Load-use on rs: LW $t0 in EX, ADD reading $t0 in ID.
        intf.ex_is_load = 1'b1; intf.ex_wreg = 5'd8;
        intf.id_rs = 5'd8; intf.id_uses_rs = 1'b1;
        #1;
        chk("lu_rs_ctrl", 32'(ctrl_vec()), 32'(C_STALL));
        tick(); exp_stall += 1;
        clear_inputs();
        #1;
        chk("lu_rs_after_ctrl", 32'(ctrl_vec()), 32'(C_RUN));
        chk("lu_rs_stall", intf.stall_cycles, 32'(exp_stall));

        // Load into $zero never creates a hazard.
        intf.ex_is_load = 1'b1; intf.ex_wreg = 5'd0;
        intf.id_rs = 5'd0; intf.id_uses_rs = 1'b1;
        #1;
        chk("lu_zero_ctrl", 32'(ctrl_vec()), 32'(C_RUN));
        tick();
        chk("lu_zero_stall", intf.stall_cycles, 32'(exp_stall));

        // Load-use through rt only.
        clear_inputs();
        intf.ex_is_load = 1'b1; intf.ex_wreg = 5'd9;
        intf.id_rs = 5'd3; intf.id_uses_rs = 1'b1;
        intf.id_rt = 5'd9; intf.id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_ctrl", 32'(ctrl_vec()), 32'(C_STALL));
        tick(); exp_stall += 1;

        // rt matches but is not read: no hazard.
        intf.id_uses_rt = 1'b0;
        #1;
        chk("lu_rt_unused_ctrl", 32'(ctrl_vec()), 32'(C_RUN));
        tick();
        chk("lu_rt_stall", intf.stall_cycles, 32'(exp_stall));

        // Taken branch overrides a load-use hazard.
        intf.id_uses_rt = 1'b1;
        intf.ex_branch_taken = 1'b1;
        #1;
        chk("br_over_lu_ctrl", 32'(ctrl_vec()), 32'(C_BRNCH));
        tick();
        chk("br_over_lu_stall", intf.stall_cycles, 32'(exp_stall));

        // MULT entering EX with an HI/LO user in ID stalls in the same cycle.
        clear_inputs();
        intf.ex_md_start = 1'b1; intf.id_uses_hilo = 1'b1;
        #1;
        chk("mult_start_ctrl", 32'(ctrl_vec()), 32'(C_STALL));
        chk("mult_start_busy", 32'(intf.md_busy), 32'd0);
        tick(); exp_stall += 1;
        intf.ex_md_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("mult_busy_c%0d", i), 32'(intf.md_busy), 32'd1);
            chk($sformatf("mult_we_c%0d", i), 32'(intf.hilo_we), 32'd0);
            chk($sformatf("mult_ctrl_c%0d", i), 32'(ctrl_vec()), 32'(C_STALL));
            tick(); exp_stall += 1;
        end
        chk("mult_done_busy", 32'(intf.md_busy), 32'd0);
        chk("mult_done_we", 32'(intf.hilo_we), 32'd1);
        chk("mult_done_ctrl", 32'(ctrl_vec()), 32'(C_RUN));
        chk("mult_stall", intf.stall_cycles, 32'(exp_stall));
        tick();
        chk("mult_we_once", 32'(intf.hilo_we), 32'd0);

        // Memory wait beats load-use, and a MULT blocked in EX does not start.
        clear_inputs();
        intf.mem_req = 1'b1; intf.mem_ready = 1'b0; intf.ex_md_start = 1'b1;
        intf.ex_is_load = 1'b1; intf.ex_wreg = 5'd4;
        intf.id_rs = 5'd4; intf.id_uses_rs = 1'b1;
        #1;
        chk("memw_lu_ctrl", 32'(ctrl_vec()), 32'(C_MEMW));
        tick(); exp_stall += 1;
        chk("memw_no_md_start", 32'(intf.md_busy), 32'd0);

        // Memory wait for 3 cycles holds a taken branch, which then flushes.
        clear_inputs();
        intf.mem_req = 1'b1; intf.mem_ready = 1'b0; intf.ex_branch_taken = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("memw_br_c%0d", i), 32'(ctrl_vec()), 32'(C_MEMW));
            tick(); exp_stall += 1;
        end
        intf.mem_ready = 1'b1;
        #1;
        chk("memw_br_release", 32'(ctrl_vec()), 32'(C_BRNCH));
        tick();
        chk("memw_br_stall", intf.stall_cycles, 32'(exp_stall));

        // DIV occupies the unit for 32 cycles.
        clear_inputs();
        intf.ex_md_start = 1'b1; intf.ex_md_is_div = 1'b1;
        tick();
        clear_inputs();
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (intf.md_busy !== 1'b1) break;
            busy_n++;
            tick();
        end
        chk("div_busy_cycles", 32'(busy_n), 32'd32);
        chk("div_done_we", 32'(intf.hilo_we), 32'd1);
        tick();

        // Reset in the middle of a DIV (countdown 10) abandons it silently.
        intf.ex_md_start = 1'b1; intf.ex_md_is_div = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < 21; i++) tick();
        chk("div_mid_busy", 32'(intf.md_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", 32'(ctrl_vec()), 32'(C_RESET));
        tick();
        chk("rst_mid_busy", 32'(intf.md_busy), 32'd0);
        chk("rst_mid_we", 32'(intf.hilo_we), 32'd0);
        chk("rst_mid_stall", intf.stall_cycles, 32'd0);
        rst = 1'b0;
        saw_we = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            saw_we = saw_we | intf.hilo_we | intf.md_busy;
        end
        chk("rst_mid_no_completion", 32'(saw_we), 32'd0);
        chk("rst_mid_stall_after", intf.stall_cycles, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the five-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Decides every cycle which pipeline registers load, hold or take a bubble. Inputs are load-use hazards, taken branches, data-memory wait states and an internally tracked multi-cycle MULT/DIV unit that owns HI/LO. Also raises the one-cycle HI/LO write strobe when a multiply or divide completes.

Parameters:
MUL_CYCLES, 4, cycles MULT/MULTU occupies the HI/LO unit (>=1)
DIV_CYCLES, 32, cycles DIV/DIVU occupies the HI/LO unit (>=1, >=MUL_CYCLES)
CNT_W, 6, width of busy countdown; must hold DIV_CYCLES-1

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_uses_hilo  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO/MULT/DIV (touches HI/LO)
ex_is_load  in  1  instruction in EX is LW/LB/LH/LBU/LHU
ex_wreg  in  5  destination register of EX instruction
ex_md_start  in  1  EX instruction is MULT/MULTU/DIV/DIVU
ex_md_is_div  in  1  qualifies ex_md_start: 1=divide
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_req  in  1  MEM-stage instruction accesses data memory
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC loads next value
ifid_en  out  1  IF/ID loads
ifid_flush  out  1  IF/ID loads a NOP instead
idex_en  out  1  ID/EX loads
idex_flush  out  1  ID/EX loads a NOP
exmem_en  out  1  EX/MEM loads
memwb_flush  out  1  MEM/WB loads a NOP
md_busy  out  1  HI/LO unit occupied (registered)
hilo_we  out  1  one-cycle strobe: write HI/LO results (registered)
stall_cycles  out  32  count of cycles with pc_en=0, saturating (registered)

Behaviour:
- Control outputs (pc_en..memwb_flush) are combinational. md_busy, hilo_we and stall_cycles are registered.
- While rst=1: pc_en=ifid_en=idex_en=exmem_en=0, all flush outputs=1.
- On rst: md_busy=0, hilo_we=0, countdown=0, stall_cycles=0, FSM=IDLE.
- Hazard terms:
  - memw = mem_req & ~mem_ready.
  - lu = ex_is_load & ex_wreg!=0 & ((id_uses_rs & id_rs==ex_wreg) | (id_uses_rt & id_rt==ex_wreg)).
  - mdh = id_uses_hilo & (md_busy | (ex_md_start & exmem_en)).
- Priority, highest first:
  1. memw: all enables 0, memwb_flush=1, other flushes 0. A branch pending in EX is held, not lost.
  2. ex_branch_taken: pc_en=ifid_en=idex_en=exmem_en=1, ifid_flush=idex_flush=1. This overrides lu and mdh because the ID instruction is squashed.
  3. lu or mdh: pc_en=ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=1.
  4. Otherwise all enables 1, all flushes 0.
- MD FSM, states IDLE and BUSY:
  - IDLE->BUSY when ex_md_start & exmem_en. Countdown loads DIV_CYCLES-1 (div) or MUL_CYCLES-1 (mult).
  - BUSY: countdown decrements every cycle, including memory stalls.
  - BUSY with countdown==0 -> IDLE, hilo_we=1 for exactly that next cycle.
  - md_busy=1 iff state BUSY.
  - ex_md_start while BUSY cannot occur because mdh blocks it. If it does occur, it is ignored.
- stall_cycles increments when pc_en=0 and rst=0. It holds at 2^32-1.
- Reset mid-operation abandons a BUSY multiply/divide with no hilo_we pulse.

Decomposition:
- Shared package (mips_pkg): REG_ZERO=5'd0, MUL_CYCLES/DIV_CYCLES defaults, NOP encoding 32'h0.
- One sub-module: md_busy_tracker (FSM + countdown + hilo_we). Hazard priority logic stays in the top.

Test Plan:
- LW $t0 in EX, ID ADD reads $t0 (rs=8, ex_wreg=8) -> pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle, then normal; stall_cycles=1.
- Same as above but ex_wreg=0 -> no stall, all enables 1.
- MULT enters EX (exmem_en=1) -> md_busy=1 for cycles 1..4, hilo_we=1 on cycle 5. MFLO in ID stalls until md_busy falls. DIV gives 32 busy cycles.
- ex_branch_taken=1 together with lu=1 -> ifid_flush=idex_flush=1, pc_en=1, no stall counted.
- mem_req=1, mem_ready=0 for 3 cycles with ex_branch_taken=1 -> all enables 0, memwb_flush=1 for 3 cycles; branch flush occurs in the 4th cycle.
- rst asserted mid-DIV (countdown=10) -> next cycle md_busy=0, hilo_we stays 0, stall_cycles=0.
